// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline register chain with per-stage valid, stall (hold) and flush (kill),
// plus saturating stall/flush event counters for performance monitoring.
module pipe_stage_chain #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic [DEPTH-1:0]           stall,
  input  logic [DEPTH-1:0]           flush,
  output logic [DEPTH-1:0]           out_valid,
  output logic [DEPTH*WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // A stall at stage k freezes k and everything younger, so hold is a suffix-OR from the oldest end.
  always_comb begin
    logic acc;
    hold = '0;
    acc  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc     = acc | stall[k];
      hold[k] = acc;
    end
  end

  assign in_ready = ~hold[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (reset || flush[0]) begin
          valid_q[0] <= 1'b0;
          data_q[0]  <= '0;
        end else if (!hold[0]) begin
          valid_q[0] <= in_valid;
          data_q[0]  <= in_data;
        end
      end
    end else begin : g_body
      // A stage whose younger neighbour is held receives a zeroed bubble instead of a duplicate.
      always_ff @(posedge clk) begin
        if (reset || flush[k]) begin
          valid_q[k] <= 1'b0;
          data_q[k]  <= '0;
        end else if (!hold[k]) begin
          if (hold[k-1]) begin
            valid_q[k] <= 1'b0;
            data_q[k]  <= '0;
          end else begin
            valid_q[k] <= valid_q[k-1];
            data_q[k]  <= data_q[k-1];
          end
        end
      end
    end
    assign out_data[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign out_valid = valid_q;

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(valid_q[k]);
    end
  end

  // Counters stick at all-ones so long runs never wrap to a misleadingly small value.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (|stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (|flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (WIDTH=8, DEPTH=4, CNT_W=4).
module tb_pipe_stage_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [DEPTH-1:0]       stall;
  logic [DEPTH-1:0]       flush;
  logic [DEPTH-1:0]       out_valid;
  logic [DEPTH*WIDTH-1:0] out_data;
  logic [2:0]             occupancy;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       flush_cnt;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush), .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compare_cnt++;
    if (actual !== expected) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                               input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
    in_valid = v;
    in_data  = d;
    stall    = st;
    flush    = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] vals);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b1, vals[i*8 +: 8], '0, '0);
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, '0, '0);
    step();
    checkOutput("rst_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_data", 64'(out_data), 64'h0);
    checkOutput("rst_occ", 64'(occupancy), 64'd0);
    checkOutput("rst_scnt", 64'(stall_cnt), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    // Fill: stage3..stage0 = 11,22,33,44
    fill(32'h11223344);
    checkOutput("fill_data", 64'(out_data), 64'h11223344);
    checkOutput("fill_valid", 64'(out_valid), 64'hF);
    checkOutput("fill_occ", 64'(occupancy), 64'd4);

    // Mid stall on stage 1
    applyStimulus(1'b1, 8'h55, 4'b0010, '0);
    checkOutput("stall_ready", 64'(in_ready), 64'd0);
    step();
    checkOutput("stall_data", 64'(out_data), 64'h22003344);
    checkOutput("stall_valid", 64'(out_valid), 64'b1011);
    checkOutput("stall_occ", 64'(occupancy), 64'd3);
    checkOutput("stall_cnt1", 64'(stall_cnt), 64'd1);

    // Flush stage 0 while offering 0x66
    applyStimulus(1'b1, 8'h66, '0, 4'b0001);
    step();
    checkOutput("flush_data", 64'(out_data), 64'h00334400);
    checkOutput("flush_valid", 64'(out_valid), 64'b0110);
    checkOutput("flush_cnt1", 64'(flush_cnt), 64'd1);
    applyStimulus(1'b0, 8'h77, '0, '0);
    step();
    checkOutput("bubble_data", 64'(out_data), 64'h33440077);
    checkOutput("bubble_valid", 64'(out_valid), 64'b1100);

    // Stall and flush on the same stage
    fill(32'hA1B2C3D4);
    checkOutput("fill2_data", 64'(out_data), 64'hA1B2C3D4);
    applyStimulus(1'b1, 8'hE5, 4'b0010, 4'b0010);
    step();
    checkOutput("sf_data", 64'(out_data), 64'hB20000D4);
    checkOutput("sf_valid", 64'(out_valid), 64'b1001);
    checkOutput("sf_scnt", 64'(stall_cnt), 64'd2);
    checkOutput("sf_fcnt", 64'(flush_cnt), 64'd2);

    // Oldest-stage stall freezes everything, then reset overrides it
    fill(32'h01020304);
    applyStimulus(1'b1, 8'h99, 4'b1000, '0);
    checkOutput("hold3_ready", 64'(in_ready), 64'd0);
    step();
    checkOutput("hold3_data", 64'(out_data), 64'h01020304);
    checkOutput("hold3_scnt", 64'(stall_cnt), 64'd3);
    reset = 1'b1;
    step();
    checkOutput("mrst_valid", 64'(out_valid), 64'h0);
    checkOutput("mrst_data", 64'(out_data), 64'h0);
    checkOutput("mrst_scnt", 64'(stall_cnt), 64'd0);
    checkOutput("mrst_fcnt", 64'(flush_cnt), 64'd0);
    checkOutput("mrst_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;

    // Flush a young stage while an older stage stalls
    fill(32'h10203040);
    applyStimulus(1'b1, 8'hAA, 4'b1000, 4'b0010);
    step();
    checkOutput("fs_data", 64'(out_data), 64'h10200040);
    checkOutput("fs_valid", 64'(out_valid), 64'b1101);
    checkOutput("fs_occ", 64'(occupancy), 64'd3);

    // Saturation of the 4-bit stall counter (starts at 1)
    applyStimulus(1'b1, 8'hBB, 4'b0001, '0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("sat_mid", 64'(stall_cnt), 64'd11);
    for (int i = 0; i < 10; i++) step();
    checkOutput("sat_end", 64'(stall_cnt), 64'hF);
    checkOutput("sat_fcnt", 64'(flush_cnt), 64'd1);
    checkOutput("sat_data", 64'(out_data), 64'h00000040);
    checkOutput("sat_valid", 64'(out_valid), 64'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised chain of DEPTH pipeline registers with per-stage valid bits, stall (hold) and flush (kill) control.
It is the successor to the fixed, always-enabled register_n pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which have no stall or flush.
A hazard unit drives stall/flush; the datapath taps each stage's data/valid.
Also keeps saturating stall/flush performance counters.

Parameters:
WIDTH, 64, payload bits per stage
DEPTH, 4, number of pipeline register stages (>=2); stage 0 is youngest (IF/ID), stage DEPTH-1 oldest (MEM/WB)
CNT_W, 16, width of performance counters

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the rising edge where it is high
in_valid  input  1  new entry offered to stage 0
in_data  input  WIDTH  payload for stage 0
in_ready  output  1  stage 0 accepts this cycle (combinational)
stall  input  DEPTH  stall[k]=1: stage k and all younger stages hold this cycle
flush  input  DEPTH  flush[k]=1: stage k register becomes a bubble next cycle
out_valid  output  DEPTH  registered valid bit of each stage
out_data  output  DEPTH*WIDTH  registered payload; stage k at [k*WIDTH +: WIDTH]
occupancy  output  $clog2(DEPTH+1)  count of set out_valid bits (combinational)
stall_cnt  output  CNT_W  cycles with any stall bit set, saturating
flush_cnt  output  CNT_W  cycles with any flush bit set, saturating

Behaviour:
- Reset: on a clock edge with reset=1, all out_valid=0, all out_data=0, stall_cnt=0, flush_cnt=0. Reset overrides stall and flush. in_ready remains combinational during reset.
- hold[k] = OR of stall[j] for j = k..DEPTH-1. A stall at stage k freezes stages 0..k.
- in_ready = ~hold[0].
- Per-stage next state, evaluated in priority order:
  1. flush[k]=1: valid[k] <= 0 and data[k] <= 0, regardless of hold. This kills the entry that would otherwise occupy stage k.
  2. Otherwise, hold[k]=1: valid[k] and data[k] keep their values.
  3. Otherwise, if k=0: valid[0] <= in_valid, data[0] <= in_data.
  4. Otherwise, if hold[k-1]=1 (k>0): insert a bubble, valid[k] <= 0, data[k] <= 0.
  5. Otherwise: valid[k] <= valid[k-1], data[k] <= data[k-1].
- Latency: an entry accepted at edge t appears at stage k after edge t+k, provided there are no stalls or flushes.
- When no stall is active, the oldest stage always advances, and its old contents are discarded, since the consumer is combinational.
- in_valid=0 with in_ready=1 loads a bubble with data = in_data. Data of invalid stages is not guaranteed zero except after flush or bubble insertion.
- Simultaneous stall[k] and flush[k]: stage k flushes, stages 0..k-1 still hold. Example: load-use stall in ID plus branch kill.
- Simultaneous flush[k] and stall[j] with j>k: stage k flushed, all stages 0..j otherwise hold.
- Counters:
  - stall_cnt increments on each non-reset edge where |stall=1.
  - flush_cnt increments on each non-reset edge where |flush=1.
  - Both saturate at all-ones and never wrap.
- occupancy = popcount(out_valid), range 0..DEPTH.
- No combinational path from stall/flush to out_data/out_valid. The only combinational path is stall -> in_ready.

Test Plan:
(bench uses WIDTH=8, DEPTH=4)
1. Fill: after reset, drive in_valid=1 with in_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, no stall -> after 4th edge out_data = {0x11,0x22,0x33,0x44} (stage3..stage0), out_valid=4'b1111, occupancy=4.
2. Mid stall: with the pipe full as in test 1, assert stall[1] for 1 cycle while offering 0x55 -> in_ready=0; stages 0,1 keep 0x44,0x33; stage 2 becomes bubble (valid 0, data 0); stage 3 = 0x22; stall_cnt=1.
3. Flush: offer 0x66 with flush[0]=1 -> stage0 valid=0, data 0x00; next cycle stage1 valid=0; flush_cnt=1.
4. Stall+flush same stage: full pipe, stall[1]=1 and flush[1]=1 -> stage1 invalid/0x00; stage0 holds its value; stage2 bubble.
5. Reset mid-operation: full pipe with stall[3]=1, assert reset for 1 edge -> all valid=0, data=0, counters=0; in_ready=0 while stall[3] remains high.
6. Saturation: (CNT_W override 4) hold stall[0]=1 for 20 cycles -> stall_cnt stops at 0xF and stays there.
